cache_fill_ctrl: RTL

Miss-handling and write-through controller that sits directly upstream of the single-cycle, byte-addressable 16-bit main memory. On a cache miss it reads a whole block (8 words by default) from memory, one word per cycle, and streams each word into the cache data array. It then pulses a tag-write strobe. When idle it also forwards write-through stores to memory, so it is the only master driving the memory port.

---
 rtl/cache_fill_ctrl_pkg.sv | 20 ++
 rtl/cache_fill_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache miss-fill / write-through controller.
// Holds the state encoding and the default block geometry.
package cache_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  localparam int WORDS_PER_BLOCK_DEF = 8;

  // A block of N 16-bit words spans 2*N bytes, so this many low address bits are cleared
  function automatic int offset_bits(input int words);
    return $clog2(2 * words);
  endfunction

  localparam int OFFSET_BITS = offset_bits(WORDS_PER_BLOCK_DEF);

endpackage

// File: rtl/cache_fill_ctrl.sv
// Miss-fill and write-through controller: sole master of the main-memory port.
// Streams a whole block into the cache on a miss, forwards stores while idle.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  localparam int CNT_W          = $clog2(WORDS_PER_BLOCK),
  localparam int OFF_W          = offset_bits(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_req,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [15:0]           i_wr_data,
  output logic                  o_wr_ack,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_wr,
  output logic [15:0]           o_mem_wdata,
  input  logic [15:0]           i_mem_rdata,
  output logic                  o_fill_we,
  output logic [CNT_W-1:0]      o_fill_word,
  output logic [15:0]           o_fill_data,
  output logic                  o_tag_we,
  output logic                  o_fill_busy,
  output logic                  o_fill_done
);

  fill_state_t           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_tag_we;
  logic                  r_fill_done;
  logic                  r_fill_busy;

  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic                  w_unused;

  // Low offset bits of the miss address and the store byte-select bit are intentionally dropped
  assign w_unused    = ^{i_miss_addr[OFF_W-1:0], i_wr_addr[0]};
  assign w_fill_addr = r_base + ADDR_WIDTH'({r_cnt, 1'b0});

  assign o_fill_word = r_cnt;
  assign o_tag_we    = r_tag_we;
  assign o_fill_done = r_fill_done;
  assign o_fill_busy = r_fill_busy;

  // State register, word counter, block base and the registered status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_base      <= {ADDR_WIDTH{1'b0}};
      r_tag_we    <= 1'b0;
      r_fill_done <= 1'b0;
      r_fill_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tag_we    <= 1'b0;
          r_fill_done <= 1'b0;
          // A pending store owns the memory port; the miss waits for a store-free cycle
          if (i_miss_req && !i_wr_req) begin
            r_base      <= {i_miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            r_cnt       <= {CNT_W{1'b0}};
            r_state     <= ST_FILL;
            r_fill_busy <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_fill_busy <= 1'b0;
          end
        end
        ST_FILL: begin
          r_cnt       <= r_cnt + 1'b1;
          r_fill_busy <= 1'b1;
          if (r_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            r_state     <= ST_DONE;
            r_tag_we    <= 1'b1;
            r_fill_done <= 1'b1;
          end else begin
            r_state     <= ST_FILL;
            r_tag_we    <= 1'b0;
            r_fill_done <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_tag_we    <= 1'b0;
          r_fill_done <= 1'b0;
          r_fill_busy <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= {CNT_W{1'b0}};
          r_tag_we    <= 1'b0;
          r_fill_done <= 1'b0;
          r_fill_busy <= 1'b0;
        end
      endcase
    end
  end

  // Memory-port and fill-port mux: stores pass straight through, fills read the block
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = {ADDR_WIDTH{1'b0}};
    o_mem_wdata = 16'h0000;
    o_wr_ack    = 1'b0;
    o_fill_we   = 1'b0;
    o_fill_data = 16'h0000;
    case (r_state)
      ST_IDLE: begin
        if (i_wr_req) begin
          o_mem_en    = 1'b1;
          o_mem_wr    = 1'b1;
          o_mem_addr  = {i_wr_addr[ADDR_WIDTH-1:1], 1'b0};
          o_mem_wdata = i_wr_data;
          o_wr_ack    = 1'b1;
        end else begin
          o_mem_en = 1'b0;
        end
      end
      ST_FILL: begin
        o_mem_en    = 1'b1;
        o_mem_addr  = w_fill_addr;
        o_fill_we   = 1'b1;
        o_fill_data = i_mem_rdata;
      end
      ST_DONE: begin
        o_mem_en = 1'b0;
      end
      default: begin
        o_mem_en = 1'b0;
      end
    endcase
  end

endmodule
